cpu_mc_core: RTL
================

# cpu_mc_core

Parametrised multicycle RISC core and the successor to the current CPU. Runs the 3-bit-opcode instruction set through a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequence. Differences from the current CPU:
- Single external memory port with a req/ready handshake (arbitrary wait states) instead of an array input.
- Register file is internal.
- Load/store, branch, move and halt are executed.
- Retire and illegal-opcode status is exported for the system bench.

## Interface
- WIDTH, 32: datapath and register width, ≥32. Instructions are always 32 bits, taken from mem_rdata[31:0].
- PC_SIZE, 10: word address width. PC increments by 1.
- NREGS, 16: register count, fixed by the 4-bit fields. R0 is an ordinary register.
- RESET_PC, 0: PC value after reset.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  1 = write (store), 0 = read (fetch/load).
- mem_addr  out  PC_SIZE  word address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  completes the pending request.
- pc  out  PC_SIZE  current PC.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  one-cycle pulse when an undefined opcode retires.
- halted  out  1  sticky; set by HALT, cleared only by reset.

## Operation

**Instruction fields**
- opcode = IR[31:29], rs = IR[28:25], rt = IR[24:21], rd = IR[20:17].
- imm16 = IR[20:5], funct = IR[4:0], funct2 = IR[24:23], imm23 = IR[22:0].
- All immediates are sign-extended to WIDTH.

**Opcodes**
- 000 ALU:
  - funct[4]=0: rd ← rs op rt.
  - funct[4]=1: rt ← rs op sext(imm16).
  - funct[3:0]: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not(op1), 6 sll, 7 srl, 8 sra, 9 slt (signed, result 1/0); 10–15 give result 0.
  - Shift amount = op2[$clog2(WIDTH)-1:0].
  - Add and sub wrap modulo 2^WIDTH; there are no flags.
- 001 load/store:
  - Address ea = (rs + sext(imm16))[PC_SIZE-1:0].
  - funct[0]=0 LD: rt ← mem[ea].
  - funct[0]=1 ST: mem[ea] ← rt.
- 010 branch:
  - Target = (NPC + sext(imm23))[PC_SIZE-1:0].
  - funct2: 00 always, 01 if rs<0 (signed), 10 if rs>0 (signed), 11 if rs==0.
  - Not taken: PC ← NPC.
- 011 move: rt ← rs.
- 111 control: IR[0]=1 HALT; IR[0]=0 NOP.
- 100, 101, 110 undefined: executed as NOP and pulse `illegal`.

**States**
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: IR ← mem_rdata[31:0], NPC ← PC+1 (wraps), go to DECODE.
- DECODE: read rs and rt from the register file, latch A, B and Immediate → EXECUTE.
- EXECUTE:
  - ALU: ALU_out ← result → WRITEBACK.
  - LD/ST: latch ea → MEMORY.
  - MOVE → WRITEBACK.
  - Branch, NOP, illegal: update PC, retire → FETCH.
  - HALT: PC ← NPC, retire → HALTED.
- MEMORY: mem_req=1, mem_addr=ea, mem_we=ST, mem_wdata=B. On mem_ready:
  - LD: latch data → WRITEBACK.
  - ST: PC ← NPC, retire → FETCH.
- WRITEBACK: write the destination register, PC ← NPC, retire → FETCH.
- HALTED: halted=1, mem_req=0. Stays until reset.

## Timing
- Reset values (asynchronous, on rst=0):
  - state=FETCH, PC=RESET_PC, all registers 0, IR 0.
  - mem_req, mem_we, retire, illegal, halted = 0.
  - mem_addr=RESET_PC, mem_wdata=0.
- Cycle counts with zero wait states (ready=1 in the first req cycle), including fetch:
  - Branch, NOP, HALT, illegal: 3.
  - ALU, MOVE, ST: 4.
  - LD: 5.
  - Each wait cycle on a request adds 1.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stable while waiting.
  - A transfer occurs on the rising edge where mem_req=1 and mem_ready=1.
  - mem_req deasserts the cycle after acceptance; there are no back-to-back requests.
  - mem_ready is ignored while mem_req=0.
- Register writes take effect at the WRITEBACK edge. The next instruction's DECODE sees the new value, so there are no hazards.
- Same-register cases are legal:
  - rs==rt: both operands read the same register.
  - ALU writing its own source register is legal.
- Reset mid-transaction: mem_req drops immediately (asynchronously) and the instruction is abandoned.
- retire is high exactly 1 cycle per instruction. illegal is high only when it coincides with retire.

## Test plan
- ALU, zero-wait: R1=5, R2=−3; add (funct=00000, rd=3) → R3=2, retire 4 cycles after the fetch request; addi with imm16=0xFFFF into rt=4 → R4=4.
- LD/ST with waits: ST R3 to ea=R0+0x10 with ready delayed 3 cycles → mem[16]=2, and addr/wdata stable during the stall; LD back into R5 → R5=2 in 5+3 cycles.
- Branches: R6=0, BZ imm23=−2 at PC=8 → next fetch address 7. BMI with R6=0 → not taken, PC=9. Unconditional branch at PC=1023 with imm23=+1 → PC wraps to 1.
- Shifts and compare: sra of 0x80000000 by 31 → 0xFFFFFFFF; slt(−1, 1) → 1; funct[3:0]=12 → 0.
- Undefined opcode 101 → illegal pulses with retire, registers unchanged, PC+1. HALT → halted=1 and mem_req stays low for 20 cycles.
- Assert rst low during a stalled LD request → mem_req=0 at once. Release → fetch from RESET_PC, all registers read 0.

Source files
------------

// File: rtl/cpu_mc_core.sv
// cpu_mc_core: multicycle 3-bit-opcode RISC core with an internal register file
// and a single req/ready memory port shared by instruction fetch and load/store.
module cpu_mc_core #(
  parameter int WIDTH    = 32,
  parameter int PC_SIZE  = 10,
  parameter int NREGS    = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic               mem_we,
  output logic [PC_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ready,
  output logic [PC_SIZE-1:0] pc,
  output logic               retire,
  output logic               illegal,
  output logic               halted
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d, npc_q, npc_d, mem_addr_q, mem_addr_d, ea, target;
  logic [31:0] ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, op2, alu_res, ea_full;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, accept, wr_en, taken;
  logic [2:0] opc;
  logic [3:0] rs, rt, rd, wr_dst;
  logic [4:0] funct;
  logic [1:0] f2;
  logic [SHW-1:0] sh;
  logic is_alu, is_ls, is_br, is_mv, is_ill, is_halt;
  assign opc     = ir_q[31:29];
  assign rs      = ir_q[28:25];
  assign rt      = ir_q[24:21];
  assign rd      = ir_q[20:17];
  assign funct   = ir_q[4:0];
  assign f2      = ir_q[24:23];
  assign is_alu  = opc == 3'd0;
  assign is_ls   = opc == 3'd1;
  assign is_br   = opc == 3'd2;
  assign is_mv   = opc == 3'd3;
  assign is_ill  = opc inside {3'd4, 3'd5, 3'd6};
  assign is_halt = opc == 3'd7 && ir_q[0];
  assign wr_dst  = (is_alu && !funct[4]) ? rd : rt;
  assign op2     = funct[4] ? imm_q : b_q;
  assign sh      = op2[SHW-1:0];
  assign ea_full = a_q + imm_q;
  assign ea      = ea_full[PC_SIZE-1:0];
  assign target  = npc_q + imm_q[PC_SIZE-1:0];
  assign taken   = f2 == 2'd0 ? 1'b1 :
                   f2 == 2'd1 ? a_q[WIDTH-1] :
                   f2 == 2'd2 ? (!a_q[WIDTH-1] && |a_q) : a_q == '0;
  assign accept  = mem_req_q && mem_ready;
  always_comb begin
    case (funct[3:0])
      4'd0:    alu_res = a_q + op2;
      4'd1:    alu_res = a_q - op2;
      4'd2:    alu_res = a_q & op2;
      4'd3:    alu_res = a_q | op2;
      4'd4:    alu_res = a_q ^ op2;
      4'd5:    alu_res = ~a_q;
      4'd6:    alu_res = a_q << sh;
      4'd7:    alu_res = a_q >> sh;
      4'd8:    alu_res = $signed(a_q) >>> sh;
      4'd9:    alu_res = WIDTH'($signed(a_q) < $signed(op2));
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    wr_en   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: if (accept) begin
        ir_d    = mem_rdata[31:0];
        npc_d   = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        imm_d   = is_br ? {{(WIDTH-23){ir_q[22]}}, ir_q[22:0]} : {{(WIDTH-16){ir_q[20]}}, ir_q[20:5]};
        state_d = S_EXEC;
      end
      S_EXEC:
        if (is_alu || is_mv) begin
          alu_d   = is_alu ? alu_res : a_q;
          state_d = S_WB;
        end else if (is_ls) begin
          state_d = S_MEM;
        end else begin
          retire  = 1'b1;
          pc_d    = (is_br && taken) ? target : npc_q;
          state_d = is_halt ? S_HALT : S_FETCH;
        end
      S_MEM: if (accept) begin
        retire  = ir_q[0];
        pc_d    = ir_q[0] ? npc_q : pc_q;
        alu_d   = mem_rdata;
        state_d = ir_q[0] ? S_FETCH : S_WB;
      end
      S_WB: begin
        wr_en   = 1'b1;
        retire  = 1'b1;
        pc_d    = npc_q;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end
  // Requests are registered; the accepting cycle never re-requests, so a store
  // that retires straight into FETCH leaves one idle cycle before the next fetch.
  always_comb begin
    mem_req_d   = (state_d == S_FETCH || state_d == S_MEM) && !accept;
    mem_we_d    = mem_req_d && state_d == S_MEM && ir_q[0];
    mem_addr_d  = state_d == S_MEM ? ea : state_d == S_FETCH ? pc_d : mem_addr_q;
    mem_wdata_d = state_d == S_MEM ? b_q : mem_wdata_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pc_q        <= PC_SIZE'(RESET_PC);
      npc_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= PC_SIZE'(RESET_PC);
      mem_wdata_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (wr_en) regs_q[wr_dst] <= alu_q;
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign illegal   = retire && state_q == S_EXEC && is_ill;
  assign halted    = state_q == S_HALT;
endmodule
